mem_resp_queue: RTL and testbench

- Parametrised successor to the single-entry MEM output register in the execute stage.
- Merges NUM_SRC memory-response channels into one in-order FIFO of DEPTH entries:
  - src 0 = store-to-load forward
  - src 1 = DMEM
  - further sources = extra DMEM ports / MMIO
- Presents the FIFO head to the CDB as the MEM functional-unit result.
- Replaces the single-entry register plus 2:1 mux: several responses can arrive in one cycle, and CDB stalls are absorbed without throttling memory immediately.

---
 rtl/uarch_pkg.sv | 17 +
 rtl/mem_resp_alloc.sv | 36 +++
 rtl/mem_resp_queue.sv | 104 ++++++++++
 tb/tb_mem_resp_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uarch_pkg.sv
// Shared micro-architecture types and sizing for the execute stage.
// writeback_packet_t is the common CDB writeback format.
package uarch_pkg;

    typedef struct packed {
        logic        is_valid;
        logic [7:0]  tag;
        logic [31:0] data;
    } writeback_packet_t;

    localparam int unsigned MEM_RESP_DEPTH    = 4;
    localparam int unsigned MEM_NUM_SRC       = 2;
    localparam int unsigned MEM_ISSUE_RESERVE = 2;
    localparam int unsigned MEM_IDX_W         = $clog2(MEM_RESP_DEPTH);
    localparam int unsigned MEM_CNT_W         = $clog2(MEM_RESP_DEPTH + 1);

endpackage

// File: rtl/mem_resp_alloc.sv
// Priority slot allocation for the memory-response queue.
// Lower source index wins; offsets place accepted packets in source order.
module mem_resp_alloc #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic [$clog2(DEPTH+1)-1:0]               free,
    input  logic [NUM_SRC-1:0]                       valids,
    output logic [NUM_SRC-1:0]                       rdys,
    output logic [NUM_SRC-1:0]                       acc,
    output logic [NUM_SRC-1:0][$clog2(DEPTH)-1:0]    offsets,
    output logic [$clog2(DEPTH+1)-1:0]               num_acc
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0] seen;

    always_comb begin
        seen    = '0;
        num_acc = '0;
        rdys    = '0;
        acc     = '0;
        offsets = '0;
        // seen counts valid lower-index sources; a source is ready only if
        // free slots remain after all of them are served
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            rdys[i]    = free > seen;
            acc[i]     = valids[i] & rdys[i];
            offsets[i] = seen[IW-1:0];
            seen       = seen + CW'(valids[i]);
            num_acc    = num_acc + CW'(acc[i]);
        end
    end

endmodule

// File: rtl/mem_resp_queue.sv
// In-order FIFO merging NUM_SRC memory-response channels into the MEM
// functional-unit result presented to the CDB.
module mem_resp_queue
    import uarch_pkg::*;
#(
    parameter int unsigned NUM_SRC       = MEM_NUM_SRC,
    parameter int unsigned DEPTH         = MEM_RESP_DEPTH,
    parameter int unsigned ISSUE_RESERVE = MEM_ISSUE_RESERVE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  writeback_packet_t            src_pkts [NUM_SRC],
    output logic [NUM_SRC-1:0]           src_rdys,
    output writeback_packet_t            fu_result,
    input  logic                         fu_cdb_gnt,
    output logic                         fu_rdy,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    writeback_packet_t          storage [DEPTH];
    logic [IW-1:0]              head;
    logic [IW-1:0]              tail;
    logic [CW-1:0]              count;
    logic [CW-1:0]              free;
    logic [CW-1:0]              num_acc;
    logic [NUM_SRC-1:0]         valids;
    logic [NUM_SRC-1:0]         acc;
    logic [NUM_SRC-1:0][IW-1:0] offsets;
    logic [IW-1:0]              wr_idx [NUM_SRC];
    logic                       pop;
    logic                       clear;

    // Modulo-DEPTH add without requiring a power-of-two depth
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input logic [CW-1:0] inc);
        logic [SW-1:0] s;
        s = SW'(base) + SW'(inc);
        if (s >= SW'(DEPTH))
            s = s - SW'(DEPTH);
        return s[IW-1:0];
    endfunction

    assign clear = rst | flush;

    always_comb begin
        fu_result = '0;
        if (count != '0) begin
            fu_result          = storage[head];
            fu_result.is_valid = 1'b1;
        end
    end

    assign pop       = fu_result.is_valid & fu_cdb_gnt;
    assign free      = CW'(DEPTH) - count + CW'(pop);
    assign fu_rdy    = (CW'(DEPTH) - count) >= CW'(ISSUE_RESERVE);
    assign occupancy = count;

    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            valids[i] = src_pkts[i].is_valid;
            wr_idx[i] = wrap_add(tail, CW'(offsets[i]));
        end
    end

    mem_resp_alloc #(
        .NUM_SRC (NUM_SRC),
        .DEPTH   (DEPTH)
    ) u_alloc (
        .free    (free),
        .valids  (valids),
        .rdys    (src_rdys),
        .acc     (acc),
        .offsets (offsets),
        .num_acc (num_acc)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop)
                head <= wrap_add(head, CW'(1));
            tail  <= wrap_add(tail, num_acc);
            count <= count + num_acc - CW'(pop);
            assert (int'(count) + int'(num_acc) <= int'(DEPTH) + int'(pop));
            assert (!(pop && count == '0));
        end
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (acc[i])
                    storage[wr_idx[i]] <= src_pkts[i];
            end
        end
    end

endmodule

// File: tb/tb_mem_resp_queue.sv
// Bench for mem_resp_queue: directed vector table, random run against a
// queue-based reference, and a DEPTH=3 wrap-around stream.
module tb_mem_resp_queue;
    import uarch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default sizing (DEPTH=4, NUM_SRC=2, ISSUE_RESERVE=2)
    logic              rst_a = 1'b1, flush_a = 1'b0, gnt_a = 1'b0;
    writeback_packet_t pkts_a [2];
    logic [1:0]        rdys_a;
    writeback_packet_t res_a;
    logic              fu_rdy_a;
    logic [2:0]        occ_a;

    // DUT B: DEPTH=3 for pointer wrap on a non-power-of-two depth
    logic              rst_b = 1'b1, flush_b = 1'b0, gnt_b = 1'b0;
    writeback_packet_t pkts_b [2];
    logic [1:0]        rdys_b;
    writeback_packet_t res_b;
    logic              fu_rdy_b;
    logic [1:0]        occ_b;

    mem_resp_queue #(.NUM_SRC(2), .DEPTH(4), .ISSUE_RESERVE(2)) dut_a (
        .clk(clk), .rst(rst_a), .flush(flush_a), .src_pkts(pkts_a), .src_rdys(rdys_a),
        .fu_result(res_a), .fu_cdb_gnt(gnt_a), .fu_rdy(fu_rdy_a), .occupancy(occ_a)
    );

    mem_resp_queue #(.NUM_SRC(2), .DEPTH(3), .ISSUE_RESERVE(1)) dut_b (
        .clk(clk), .rst(rst_b), .flush(flush_b), .src_pkts(pkts_b), .src_rdys(rdys_b),
        .fu_result(res_b), .fu_cdb_gnt(gnt_b), .fu_rdy(fu_rdy_b), .occupancy(occ_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic writeback_packet_t mk(input logic [7:0] t, input bit v);
        writeback_packet_t p;
        p.is_valid = v;
        p.tag      = t;
        p.data     = {t, ~t, t ^ 8'h5a, 8'hc3};
        return p;
    endfunction

    // Two-source acceptance rule: source 1 needs a slot beyond any valid source 0
    function automatic logic [1:0] exp_rdys(input int free, input bit v0);
        logic [1:0] r;
        r[0] = free > 0;
        r[1] = free > (v0 ? 1 : 0);
        return r;
    endfunction

    typedef struct {
        bit         rst, flush, gnt, v0;
        logic [7:0] t0;
        bit         v1;
        logic [7:0] t1;
        bit         chk_en, ev;
        logic [7:0] et;
        int         eocc;
        bit         erdy;
        logic [1:0] erdys;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mkv(input bit r, f, g, v0, input int t0, input bit v1, input int t1,
                                 input bit c, ev, input int et, eo, input bit er, input logic [1:0] ers);
        vec_t v;
        v.rst = r; v.flush = f; v.gnt = g; v.v0 = v0; v.t0 = 8'(t0); v.v1 = v1; v.t1 = 8'(t1);
        v.chk_en = c; v.ev = ev; v.et = 8'(et); v.eocc = eo; v.erdy = er; v.erdys = ers;
        return v;
    endfunction

    writeback_packet_t qa [$];
    writeback_packet_t qb [$];
    writeback_packet_t exp_res, p0, p1;
    bit                r, f, g, v0, v1, pop;
    int                sz, free, next_tag, out_cnt;
    logic [1:0]        er;

    initial begin
        pkts_a[0] = '0; pkts_a[1] = '0;
        pkts_b[0] = '0; pkts_b[1] = '0;

        //            rst flu gnt v0 t0 v1 t1 chk ev et occ rdy rdys
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2'b00));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 2'b11));
        tbl.push_back(mkv(0, 0, 1, 1, 5, 1, 9,  1, 0, 0, 0, 1, 2'b11));
        tbl.push_back(mkv(0, 0, 1, 0, 0, 0, 0,  1, 1, 5, 2, 1, 2'b11));
        tbl.push_back(mkv(0, 0, 1, 0, 0, 0, 0,  1, 1, 9, 1, 1, 2'b11));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 2'b11));
        tbl.push_back(mkv(0, 0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 1, 2'b11));
        tbl.push_back(mkv(0, 0, 0, 1, 2, 0, 0,  1, 1, 1, 1, 1, 2'b11));
        tbl.push_back(mkv(0, 0, 0, 1, 3, 0, 0,  1, 1, 1, 2, 1, 2'b11));
        tbl.push_back(mkv(0, 0, 0, 1, 4, 0, 0,  1, 1, 1, 3, 0, 2'b01));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 4, 0, 2'b00));
        tbl.push_back(mkv(0, 0, 1, 1, 5, 1, 6,  1, 1, 1, 4, 0, 2'b01));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0,  1, 1, 2, 4, 0, 2'b00));
        tbl.push_back(mkv(0, 0, 1, 0, 0, 0, 0,  1, 1, 2, 4, 0, 2'b11));
        tbl.push_back(mkv(0, 0, 1, 0, 0, 0, 0,  1, 1, 3, 3, 0, 2'b11));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0,  1, 1, 4, 2, 1, 2'b11));
        tbl.push_back(mkv(0, 0, 0, 1, 10, 0, 0, 1, 1, 4, 2, 1, 2'b11));
        tbl.push_back(mkv(0, 1, 0, 0, 0, 1, 7,  1, 1, 4, 3, 0, 2'b11));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 2'b11));
        tbl.push_back(mkv(0, 0, 0, 1, 11, 0, 0, 1, 0, 0, 0, 1, 2'b11));
        tbl.push_back(mkv(0, 0, 1, 0, 0, 1, 12, 1, 1, 11, 1, 1, 2'b11));
        tbl.push_back(mkv(0, 0, 1, 0, 0, 0, 0,  1, 1, 12, 1, 1, 2'b11));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 2'b11));
        tbl.push_back(mkv(0, 0, 0, 1, 13, 0, 0, 1, 0, 0, 0, 1, 2'b11));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 1, 14, 1, 1, 13, 1, 1, 2'b11));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 2'b11));

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            rst_a = tbl[k].rst; flush_a = tbl[k].flush; gnt_a = tbl[k].gnt;
            pkts_a[0] = mk(tbl[k].t0, tbl[k].v0);
            pkts_a[1] = mk(tbl[k].t1, tbl[k].v1);
            #1;
            if (tbl[k].chk_en) begin
                exp_res = tbl[k].ev ? mk(tbl[k].et, 1'b1) : '0;
                chk($sformatf("v%0d_result", k), 64'(res_a), 64'(exp_res));
                chk($sformatf("v%0d_occ", k), 64'(occ_a), 64'(tbl[k].eocc));
                chk($sformatf("v%0d_fu_rdy", k), 64'(fu_rdy_a), 64'(tbl[k].erdy));
                chk($sformatf("v%0d_src_rdys", k), 64'(rdys_a), 64'(tbl[k].erdys));
            end
        end

        // Random traffic on DUT A against a queue reference
        @(negedge clk);
        rst_a = 1'b1; flush_a = 1'b0; gnt_a = 1'b0;
        pkts_a[0] = '0; pkts_a[1] = '0;
        qa.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            r  = ($urandom_range(63) == 0);
            f  = ($urandom_range(39) == 0);
            g  = $urandom_range(1);
            v0 = $urandom_range(1);
            v1 = $urandom_range(1);
            p0 = mk(8'($urandom), v0); p0.data = $urandom;
            p1 = mk(8'($urandom), v1); p1.data = $urandom;
            rst_a = r; flush_a = f; gnt_a = g;
            pkts_a[0] = p0; pkts_a[1] = p1;
            #1;
            sz      = qa.size();
            exp_res = (sz != 0) ? qa[0] : '0;
            pop     = (sz != 0) && g;
            free    = 4 - sz + (pop ? 1 : 0);
            er      = exp_rdys(free, v0);
            chk("rand_result", 64'(res_a), 64'(exp_res));
            chk("rand_occ", 64'(occ_a), 64'(sz));
            chk("rand_fu_rdy", 64'(fu_rdy_a), 64'((4 - sz) >= 2));
            chk("rand_src_rdys", 64'(rdys_a), 64'(er));
            if (r || f) begin
                qa.delete();
            end else begin
                if (pop) void'(qa.pop_front());
                if (v0 && er[0]) qa.push_back(p0);
                if (v1 && er[1]) qa.push_back(p1);
            end
        end
        @(negedge clk);
        rst_a = 1'b1; pkts_a[0] = '0; pkts_a[1] = '0;

        // DEPTH=3 wrap: tags 1..10 in, gnt toggling, must exit 1..10 in order
        @(negedge clk);
        rst_b = 1'b0;
        qb.delete();
        next_tag = 1;
        out_cnt  = 0;
        for (int c = 0; c < 200 && out_cnt < 10; c++) begin
            @(negedge clk);
            g  = c[0];
            v0 = (next_tag <= 10) && ($urandom_range(3) != 0);
            v1 = (next_tag + (v0 ? 1 : 0) <= 10) && ($urandom_range(3) != 0);
            p0 = mk(8'(next_tag), v0);
            p1 = mk(8'(next_tag + (v0 ? 1 : 0)), v1);
            gnt_b = g; pkts_b[0] = p0; pkts_b[1] = p1;
            #1;
            sz      = qb.size();
            exp_res = (sz != 0) ? qb[0] : '0;
            pop     = (sz != 0) && g;
            free    = 3 - sz + (pop ? 1 : 0);
            er      = exp_rdys(free, v0);
            chk("wrap_result", 64'(res_b), 64'(exp_res));
            chk("wrap_occ", 64'(occ_b), 64'(sz));
            chk("wrap_fu_rdy", 64'(fu_rdy_b), 64'((3 - sz) >= 1));
            chk("wrap_src_rdys", 64'(rdys_b), 64'(er));
            if (pop) begin
                chk("wrap_order", 64'(res_b.tag), 64'(out_cnt + 1));
                out_cnt++;
                void'(qb.pop_front());
            end
            if (v0 && er[0]) begin qb.push_back(p0); next_tag++; end
            if (v1 && er[1]) begin qb.push_back(p1); next_tag++; end
        end
        chk("wrap_exit_count", 64'(out_cnt), 64'd10);
        @(negedge clk);
        gnt_b = 1'b0; pkts_b[0] = '0; pkts_b[1] = '0;
        #1;
        chk("wrap_drained_occ", 64'(occ_b), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
